// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EX/MEM/WB sequencer with a memory ready handshake.
// Define MC_CU_BLE_EN to decode ble (opcode 011011); otherwise that opcode is illegal.
module mc_control_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        z,
    input  logic        le,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pcsource,
    output logic [3:0]  aluc,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic        sext,
    output logic        shift,
    output logic [1:0]  regdst,
    output logic        m2reg,
    output logic        wreg,
    output logic        illegal,
    output logic [31:0] pc_init
);
    typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb} state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
`ifdef MC_CU_BLE_EN
    localparam logic [5:0] OpBle   = 6'b011011;
`endif

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic       dec_legal, is_rtype, is_jr, is_j, is_jal, is_lw, is_sw;
    logic       is_beq, is_bne, is_ble, br_taken;
    logic [3:0] ex_aluc;
    logic [1:0] ex_srcb;
    logic       ex_sext, ex_shift;

    // Instruction decode; only consumed from ID onward.
    always_comb begin
        dec_legal = 1'b1;
        is_rtype  = 1'b0;
        is_jr     = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_ble    = 1'b0;
        ex_aluc   = 4'b0000;
        ex_srcb   = 2'b00;
        ex_sext   = 1'b0;
        ex_shift  = 1'b0;
        case (op)
            OpRtype: begin
                is_rtype = 1'b1;
                case (func)
                    6'b100000: ex_aluc = 4'b0000;
                    6'b100010: ex_aluc = 4'b0100;
                    6'b100100: ex_aluc = 4'b0001;
                    6'b100101: ex_aluc = 4'b0101;
                    6'b100110: ex_aluc = 4'b0010;
                    6'b000000: begin ex_aluc = 4'b0011; ex_shift = 1'b1; end
                    6'b000010: begin ex_aluc = 4'b0111; ex_shift = 1'b1; end
                    6'b000011: begin ex_aluc = 4'b1111; ex_shift = 1'b1; end
                    6'b001000: is_jr = 1'b1;
                    default:   dec_legal = 1'b0;
                endcase
            end
            OpJ:    is_j = 1'b1;
            OpJal:  is_jal = 1'b1;
            OpBeq:  begin is_beq = 1'b1; ex_aluc = 4'b0100; end
            OpBne:  begin is_bne = 1'b1; ex_aluc = 4'b0100; end
            OpAddi: begin ex_srcb = 2'b10; ex_sext = 1'b1; end
            OpAndi: begin ex_srcb = 2'b10; ex_aluc = 4'b0001; end
            OpOri:  begin ex_srcb = 2'b10; ex_aluc = 4'b0101; end
            OpXori: begin ex_srcb = 2'b10; ex_aluc = 4'b0010; end
            OpLui:  begin ex_srcb = 2'b10; ex_aluc = 4'b0110; end
            OpLw:   begin is_lw = 1'b1; ex_srcb = 2'b10; ex_sext = 1'b1; end
            OpSw:   begin is_sw = 1'b1; ex_srcb = 2'b10; ex_sext = 1'b1; end
`ifdef MC_CU_BLE_EN
            OpBle:  begin is_ble = 1'b1; ex_aluc = 4'b1011; end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    assign br_taken = (is_beq & z) | (is_bne & ~z) | (is_ble & le);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pcsource  = 2'b00;
        aluc      = 4'b0000;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        sext      = 1'b0;
        shift     = 1'b0;
        regdst    = 2'b00;
        m2reg     = 1'b0;
        wreg      = 1'b0;
        if (reset) begin
            state_d   = StIf;
            illegal_d = 1'b0;
        end else begin
            // EX operand selects stay up through MEM/WB so the ALU result remains valid.
            if (state_q inside {StEx, StMem, StWb}) begin
                alusrca = 1'b1;
                alusrcb = ex_srcb;
                sext    = ex_sext;
                shift   = ex_shift;
                aluc    = ex_aluc;
            end
            unique case (state_q)
                StIf: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = StId;
                    end
                end
                StId: begin
                    alusrcb = 2'b11;
                    sext    = 1'b1;
                    if (!dec_legal) begin
                        illegal_d = 1'b1;
                        state_d   = StIf;
                    end else if (is_j || is_jal) begin
                        pc_we    = 1'b1;
                        pcsource = 2'b10;
                        if (is_jal) begin
                            wreg   = 1'b1;
                            regdst = 2'b10;
                        end
                        state_d  = StIf;
                    end else begin
                        state_d = StEx;
                    end
                end
                StEx: begin
                    if (is_jr) begin
                        pc_we    = 1'b1;
                        pcsource = 2'b11;
                        state_d  = StIf;
                    end else if (is_beq || is_bne || is_ble) begin
                        pc_we    = br_taken;
                        pcsource = 2'b01;
                        state_d  = StIf;
                    end else if (is_lw || is_sw) begin
                        state_d = StMem;
                    end else begin
                        state_d = StWb;
                    end
                end
                StMem: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = is_sw;
                    if (mem_ready) state_d = is_sw ? StIf : StWb;
                end
                StWb: begin
                    wreg    = 1'b1;
                    regdst  = is_rtype ? 2'b01 : 2'b00;
                    m2reg   = is_lw;
                    state_d = StIf;
                end
                default: state_d = StIf;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIf;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
    assign pc_init = RESET_PC;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: instruction table with zero-wait memory plus
// hand-written wait-state and reset-abort sequences.
module tb_mc_control_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  op, func;
    logic        z, le, mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pcsource, alusrcb, regdst;
    logic [3:0]  aluc;
    logic        alusrca, sext, shift, m2reg, wreg, illegal;
    logic [31:0] pc_init;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mc_control_unit dut (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .le(le),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pcsource(pcsource), .aluc(aluc),
        .alusrca(alusrca), .alusrcb(alusrcb), .sext(sext), .shift(shift),
        .regdst(regdst), .m2reg(m2reg), .wreg(wreg), .illegal(illegal), .pc_init(pc_init)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       z;
        logic       le;
        int         cycles;
        logic       chk_alu;
        logic [3:0] aluc;
        logic       shift;
        logic       chk_src;
        logic [1:0] srcb;
        logic       sext;
        logic       pc_we;
        logic [1:0] pcsrc;
        logic       wreg;
        logic [1:0] regdst;
        logic       m2reg;
        logic       mem_we;
        logic       illegal;
    } vec_t;

    typedef struct {
        logic       mem_req, iord, ir_we, pc_we, wreg, m2reg, mem_we, shift, sext;
        logic [1:0] pcsource, alusrcb, regdst;
        logic [3:0] aluc;
    } rec_t;

    vec_t vecs[$];
    rec_t recs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t snap();
        rec_t r;
        r.mem_req = mem_req; r.iord = iord; r.ir_we = ir_we; r.pc_we = pc_we;
        r.wreg = wreg; r.m2reg = m2reg; r.mem_we = mem_we; r.shift = shift;
        r.sext = sext; r.pcsource = pcsource; r.alusrcb = alusrcb;
        r.regdst = regdst; r.aluc = aluc;
        return r;
    endfunction

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic zz,
                                input logic ll, input int cyc, input logic ca,
                                input logic [3:0] a, input logic sh, input logic cs,
                                input logic [1:0] sb, input logic se, input logic pw,
                                input logic [1:0] ps, input logic wr, input logic [1:0] rd,
                                input logic m2, input logic mw, input logic il);
        vec_t v;
        v.op = o; v.func = f; v.z = zz; v.le = ll; v.cycles = cyc; v.chk_alu = ca;
        v.aluc = a; v.shift = sh; v.chk_src = cs; v.srcb = sb; v.sext = se;
        v.pc_we = pw; v.pcsrc = ps; v.wreg = wr; v.regdst = rd; v.m2reg = m2;
        v.mem_we = mw; v.illegal = il;
        return v;
    endfunction

    // Entered at the negedge of an IF cycle; returns at the negedge of the next IF cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int  n;
        bit  done;
        int  last;
        op = v.op; func = v.func; z = v.z; le = v.le; mem_ready = 1'b1;
        #1;
        n = 0;
        done = 0;
        while (!done) begin
            recs[n] = snap();
            n++;
            @(negedge clock);
            if (mem_req && !iord) begin
                done = 1;
            end else if (n >= 12) begin
                chk($sformatf("v%0d timeout", idx), 32'(n), 32'(v.cycles));
                done = 1;
            end
        end
        chk($sformatf("v%0d cycles", idx), 32'(n), 32'(v.cycles));
        chk($sformatf("v%0d if ir_we", idx), 32'(recs[0].ir_we), 32'd1);
        if (n >= 2) chk($sformatf("v%0d id aluc", idx), 32'(recs[1].aluc), 32'd0);
        if (v.cycles >= 3 && n >= 3) begin
            if (v.chk_alu) chk($sformatf("v%0d ex aluc", idx), 32'(recs[2].aluc), 32'(v.aluc));
            chk($sformatf("v%0d ex shift", idx), 32'(recs[2].shift), 32'(v.shift));
            if (v.chk_src) begin
                chk($sformatf("v%0d ex alusrcb", idx), 32'(recs[2].alusrcb), 32'(v.srcb));
                chk($sformatf("v%0d ex sext", idx), 32'(recs[2].sext), 32'(v.sext));
            end
        end
        last = (n > 0) ? n - 1 : 0;
        chk($sformatf("v%0d last pc_we", idx), 32'(recs[last].pc_we), 32'(v.pc_we));
        if (v.pc_we)
            chk($sformatf("v%0d last pcsource", idx), 32'(recs[last].pcsource), 32'(v.pcsrc));
        chk($sformatf("v%0d last wreg", idx), 32'(recs[last].wreg), 32'(v.wreg));
        if (v.wreg) begin
            chk($sformatf("v%0d last regdst", idx), 32'(recs[last].regdst), 32'(v.regdst));
            chk($sformatf("v%0d last m2reg", idx), 32'(recs[last].m2reg), 32'(v.m2reg));
        end
        chk($sformatf("v%0d last mem_we", idx), 32'(recs[last].mem_we), 32'(v.mem_we));
        chk($sformatf("v%0d illegal", idx), 32'(illegal), 32'(v.illegal));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //     op         func       z  le cyc ca aluc    sh cs srcb  se pw pcs  wr rdst  m2 mw il
        vecs.push_back(mk(6'h00, 6'b100000, 0, 0, 4, 1, 4'b0000, 0, 1, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b100010, 0, 0, 4, 1, 4'b0100, 0, 1, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b100100, 0, 0, 4, 1, 4'b0001, 0, 1, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b100101, 0, 0, 4, 1, 4'b0101, 0, 1, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b100110, 0, 0, 4, 1, 4'b0010, 0, 1, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b000000, 0, 0, 4, 1, 4'b0011, 1, 0, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b000010, 0, 0, 4, 1, 4'b0111, 1, 0, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b000011, 0, 0, 4, 1, 4'b1111, 1, 0, 2'b00, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(6'b001000, 6'h15, 0, 0, 4, 1, 4'b0000, 0, 1, 2'b10, 1, 0, 2'b00, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b001100, 6'h00, 0, 0, 4, 1, 4'b0001, 0, 1, 2'b10, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b001101, 6'h00, 0, 0, 4, 1, 4'b0101, 0, 1, 2'b10, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b001110, 6'h00, 0, 0, 4, 1, 4'b0010, 0, 1, 2'b10, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b001111, 6'h00, 0, 0, 4, 1, 4'b0110, 0, 0, 2'b10, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b100011, 6'h00, 0, 0, 5, 1, 4'b0000, 0, 1, 2'b10, 1, 0, 2'b00, 1, 2'b00, 1, 0, 0));
        vecs.push_back(mk(6'b101011, 6'h00, 0, 0, 4, 1, 4'b0000, 0, 1, 2'b10, 1, 0, 2'b00, 0, 2'b00, 0, 1, 0));
        vecs.push_back(mk(6'b000100, 6'h00, 0, 0, 3, 1, 4'b0100, 0, 0, 2'b00, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b000100, 6'h00, 1, 0, 3, 1, 4'b0100, 0, 0, 2'b00, 0, 1, 2'b01, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b000101, 6'h00, 0, 1, 3, 1, 4'b0100, 0, 0, 2'b00, 0, 1, 2'b01, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b000101, 6'h00, 1, 0, 3, 1, 4'b0100, 0, 0, 2'b00, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'h00, 6'b001000, 0, 0, 3, 0, 4'b0000, 0, 0, 2'b00, 0, 1, 2'b11, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b000010, 6'h00, 0, 0, 2, 0, 4'b0000, 0, 0, 2'b00, 0, 1, 2'b10, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b000011, 6'h00, 0, 0, 2, 0, 4'b0000, 0, 0, 2'b00, 0, 1, 2'b10, 1, 2'b10, 0, 0, 0));
`ifdef MC_CU_BLE_EN
        vecs.push_back(mk(6'b011011, 6'h00, 0, 1, 3, 1, 4'b1011, 0, 0, 2'b00, 0, 1, 2'b01, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(6'b011011, 6'h00, 1, 0, 3, 1, 4'b1011, 0, 0, 2'b00, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0));
`else
        vecs.push_back(mk(6'b011011, 6'h00, 0, 1, 2, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1));
`endif
        vecs.push_back(mk(6'b111111, 6'h00, 0, 0, 2, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1));
        vecs.push_back(mk(6'h00, 6'b111111, 0, 0, 2, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1));

        // Reset held two cycles; everything quiet, then fetch starts at once.
        reset = 1'b1; mem_ready = 1'b1; op = 6'h00; func = 6'b100000; z = 1'b0; le = 1'b0;
        @(negedge clock);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst ir_we", 32'(ir_we), 32'd0);
        @(negedge clock);
        chk("rst pc_we", 32'(pc_we), 32'd0);
        chk("rst aluc", 32'(aluc), 32'd0);
        reset = 1'b0;
        #1;
        chk("post-rst mem_req", 32'(mem_req), 32'd1);
        chk("post-rst iord", 32'(iord), 32'd0);
        chk("post-rst aluc", 32'(aluc), 32'd0);
        chk("post-rst alusrcb", 32'(alusrcb), 32'd1);
        chk("post-rst ir_we", 32'(ir_we), 32'd1);
        chk("post-rst pc_we", 32'(pc_we), 32'd1);
        chk("post-rst illegal", 32'(illegal), 32'd0);
        chk("pc_init", pc_init, 32'h0000_0000);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // lw with three wait cycles in MEM: IF ID EX MEM MEM MEM MEM WB = 8 cycles.
        begin
            logic mr_script[8];
            int   held;
            mr_script = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            op = 6'b100011; func = 6'h00; mem_ready = 1'b1;
            #1;
            chk("lw if ir_we", 32'(ir_we), 32'd1);
            held = 0;
            for (int c = 1; c < 8; c++) begin
                @(negedge clock);
                mem_ready = mr_script[c];
                #1;
                if (c == 2) chk("lw ex mem_req", 32'(mem_req), 32'd0);
                if (c >= 3 && c <= 6) begin
                    chk($sformatf("lw mem c%0d req/iord", c), 32'({mem_req, iord}), 32'd3);
                    if (mem_req && iord) held++;
                end
                if (c == 7) begin
                    chk("lw wb wreg", 32'(wreg), 32'd1);
                    chk("lw wb m2reg", 32'(m2reg), 32'd1);
                end
            end
            chk("lw mem_req held", 32'(held), 32'd4);
            @(negedge clock);
            mem_ready = 1'b0;
            #1;
            chk("lw back in IF", 32'({mem_req, iord}), 32'd2);
        end

        // Fetch stall: two cycles without mem_ready, then add completes.
        op = 6'h00; func = 6'b100000;
        chk("stall ir_we", 32'(ir_we), 32'd0);
        @(negedge clock);
        chk("stall held req/iord", 32'({mem_req, iord}), 32'd2);
        chk("stall pc_we", 32'(pc_we), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("stall release ir_we", 32'(ir_we), 32'd1);
        repeat (3) @(negedge clock);
        chk("stall add wb wreg", 32'(wreg), 32'd1);
        @(negedge clock);
        #1;

        // Execute an illegal opcode so the sticky flag is set, then abort an ori in WB.
        op = 6'b111111;
        repeat (2) @(negedge clock);
        chk("illegal sticky", 32'(illegal), 32'd1);
        op = 6'b001101;
        repeat (3) @(negedge clock);
        chk("ori wb wreg", 32'(wreg), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst in wb wreg", 32'(wreg), 32'd0);
        chk("rst in wb pc_we", 32'(pc_we), 32'd0);
        @(negedge clock);
        chk("rst cleared illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        #1;
        chk("after abort in IF", 32'({mem_req, iord}), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control unit that decodes MIPS-subset instructions and drives the datapath ALU through its 4-bit `aluc` code. It consumes the ALU's `z` and `le` flags to resolve branches. It sequences fetch, decode, execute, memory and writeback with a ready handshake toward the shared instruction/data memory. It sits between the instruction register and the datapath in the multi-cycle CPU.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; exported through `pc_init`.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  6  instruction bits [31:26], valid from the ID state onward.
- `func`  in  6  instruction bits [5:0].
- `z`  in  1  ALU zero flag.
- `le`  in  1  ALU less-or-equal flag; valid when `aluc` = 4'b1011.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held high until `mem_ready`.
- `mem_we`  out  1  write qualifier for `mem_req` (store).
- `iord`  out  1  address select: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  instruction register load strobe.
- `pc_we`  out  1  PC load strobe.
- `pcsource`  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 register (jr).
- `aluc`  out  4  ALU operation code.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = rs; shift instructions use sa.
- `alusrcb`  out  2  ALU B select: 00 rt, 01 constant 4, 10 extended imm, 11 extended imm<<2.
- `sext`  out  1  sign-extend the immediate (0 = zero-extend).
- `shift`  out  1  ALU A takes sa.
- `regdst`  out  2  write register: 00 rt, 01 rd, 10 $31.
- `m2reg`  out  1  writeback data from memory.
- `wreg`  out  1  register file write strobe.
- `illegal`  out  1  sticky flag for an unrecognised opcode or function; cleared by reset.
- `pc_init`  out  32  constant `RESET_PC`.

## Operation
- FSM states: IF, ID, EX, MEM, WB.
- **IF**
  - Assert `mem_req=1`, `iord=0`, `alusrca=0`, `alusrcb=01`, `aluc=0000`.
  - On `mem_ready`, pulse `ir_we` and `pc_we` with `pcsource=00`, then go to ID.
  - Without `mem_ready`, stay in IF.
- **ID**
  - Compute the branch target: `alusrcb=11`, `sext=1`, `aluc=0000`.
  - `j` (000010) and `jal` (000011): pulse `pc_we` with `pcsource=10`. `jal` also asserts `wreg`, `regdst=10`, `m2reg=0`. Then go to IF.
  - Illegal encodings: set `illegal` and return to IF (no operation).
  - All other instructions go to EX.
- **EX: ALU code per instruction**
  - add 0000, sub 0100, and 0001, or 0101, xor 0010.
  - sll 0011, srl 0111, sra 1111; these also assert `shift`.
  - addi 0000 (sext), andi 0001, ori 0101, xori 0010 (zero-ext), lui 0110.
  - lw/sw 0000 (sext).
  - beq/bne 0100.
  - ble (opcode 011011) 1011.
- **EX: branches and jr**
  - beq: pulse `pc_we` with `pcsource=01` iff `z=1`.
  - bne: same, iff `z=0`.
  - ble: same, iff `le=1`.
  - jr (func 001000): `pcsource=11`, `pc_we`.
  - All four return to IF.
- **EX: next state for everything else**
  - lw/sw go to MEM.
  - R-type and immediate ALU instructions go to WB.
- **MEM**
  - Assert `mem_req=1`, `iord=1`, `mem_we` = (op==sw).
  - On `mem_ready`: sw returns to IF, lw goes to WB.
- **WB**
  - Pulse `wreg` for one cycle.
  - `regdst`: R-type 01, otherwise 00.
  - `m2reg` = lw.
  - Return to IF.
- `aluc` is a combinational function of state, `op` and `func`. Strobes are single-cycle except `mem_req`.

## Timing
- Reset (synchronous, highest priority)
  - State goes to IF; `illegal` clears to 0.
  - All strobes read 0 and `aluc` reads 0000 during the reset cycle.
  - Reset asserted mid-instruction abandons it; no `wreg`/`mem_we`/`pc_we` is issued in that cycle.
- Latency with zero-wait memory (`mem_ready` high the cycle `mem_req` rises):
  - j/jal/illegal: 2 cycles.
  - branches/jr: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle `mem_ready` is low adds one cycle in IF or MEM.
- `mem_ready` is ignored outside IF and MEM.
- `mem_req`, `iord` and `mem_we` stay stable while waiting.
- Branch decisions sample `z`/`le` in the EX cycle only.

## Configuration
- `MC_CU_BLE_EN` defined: the ble opcode 011011 is decoded as described, issuing `aluc=1011` and branching on `le`.
- Undefined: opcode 011011 is illegal. It sets `illegal`, returns to IF after ID, and never drives `aluc=1011`.

## Test plan
- Reset held 2 cycles, then released with `mem_ready=1` → `mem_req=1`, `iord=0`, `aluc=0000` in the first cycle; `ir_we` and `pc_we` pulse the same cycle.
- R-type add (op 000000, func 100000) with zero-wait memory → `aluc=0000` in EX; `wreg=1`, `regdst=01` in cycle 4; back in IF at cycle 5.
- lw with `mem_ready` delayed 3 cycles in MEM → `mem_req`/`iord=1` held 4 cycles; `wreg=1`, `m2reg=1` in the cycle after `mem_ready`; total 8 cycles.
- beq with `z=0`, then with `z=1` → no `pc_we` in EX, then `pc_we=1` with `pcsource=01`; each takes 3 cycles.
- ble with `le=1` → `aluc=1011`, `pc_we`, `pcsource=01`. Rebuilt without `MC_CU_BLE_EN` → `illegal=1`, no EX state.
- Reset asserted during the WB cycle of an ori → `wreg=0` that cycle; state is IF next cycle; `illegal=0`.
